uart_tx_framer: RTL and testbench

//  UART transmit framer/serializer. Sits upstream of the baud counter: drives
//  its 'shifting' enable, consumes its one-cycle 'shift' pulses and advances
//  one serial bit per pulse. Builds start + 7/8 data (LSB first) + optional

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_framer.sv | 116 +++++++++++
 tb/tb_uart_tx_framer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, frame sizing, baud select
// codes and the parity helper used when building a frame.
package uart_pkg;

    localparam int FRAME_MAX = 12;

    typedef enum logic {
        IDLE,
        SEND
    } tx_state_t;

    typedef enum logic [1:0] {
        BAUD_9600   = 2'd0,
        BAUD_19200  = 2'd1,
        BAUD_57600  = 2'd2,
        BAUD_115200 = 2'd3
    } baud_select_t;

    // Parity covers only the bits actually sent; bit 7 is ignored in 7-bit mode.
    function automatic logic par_bit(input logic [7:0] data, input logic eight, input logic odd);
        logic [7:0] bits;
        bits = eight ? data : {1'b0, data[6:0]};
        return odd ? ~^bits : ^bits;
    endfunction

endpackage

// File: rtl/uart_tx_framer.sv
// UART transmit framer: builds start/data/parity/stop frame and shifts it out
// one bit per baud 'shift' pulse onto a registered serial line.
module uart_tx_framer #(
    parameter int STOP_BITS = 1,
    parameter int FRAME_MAX = uart_pkg::FRAME_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    input  logic       eight,
    input  logic       parity_en,
    input  logic       ohel,
    input  logic       shift,
    output logic       shifting,
    output logic       tx,
    output logic       ready,
    output logic       done
);
    import uart_pkg::*;

    tx_state_t              state_reg;
    logic [FRAME_MAX-1:0]   frame_reg;
    logic [FRAME_MAX-1:0]   frame_load;
    logic [FRAME_MAX-1:0]   frame_next;
    logic [3:0]             bit_cnt_reg;
    logic [3:0]             last_idx_reg;
    logic [3:0]             last_idx_load;
    logic                   tx_reg;
    logic                   shifting_reg;
    logic                   ready_reg;
    logic                   done_reg;

    // Unused upper positions stay at one, so stop bits come for free.
    always_comb begin
        frame_load    = '1;
        frame_load[0] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            frame_load[1+i] = data[i];
        end
        if (eight) begin
            frame_load[8] = data[7];
            if (parity_en) begin
                frame_load[9] = par_bit(data, eight, ohel);
            end
        end else if (parity_en) begin
            frame_load[8] = par_bit(data, eight, ohel);
        end
        last_idx_load = 4'(STOP_BITS) + (eight ? 4'd8 : 4'd7) + {3'b000, parity_en};
    end

    generate
        for (genvar gi = 0; gi < FRAME_MAX; gi++) begin : g_shift
            if (gi == FRAME_MAX - 1) begin : g_top
                assign frame_next[gi] = 1'b1;
            end else begin : g_mid
                assign frame_next[gi] = frame_reg[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            frame_reg    <= '1;
            bit_cnt_reg  <= 4'd0;
            last_idx_reg <= 4'd0;
            tx_reg       <= 1'b1;
            shifting_reg <= 1'b0;
            ready_reg    <= 1'b1;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (load && ready_reg) begin
                        state_reg    <= SEND;
                        frame_reg    <= frame_load;
                        last_idx_reg <= last_idx_load;
                        bit_cnt_reg  <= 4'd0;
                        tx_reg       <= frame_load[0];
                        shifting_reg <= 1'b1;
                        ready_reg    <= 1'b0;
                    end
                end
                SEND: begin
                    if (shift) begin
                        if (bit_cnt_reg == last_idx_reg) begin
                            // Last stop bit time has elapsed: release the line.
                            state_reg    <= IDLE;
                            frame_reg    <= '1;
                            bit_cnt_reg  <= 4'd0;
                            tx_reg       <= 1'b1;
                            shifting_reg <= 1'b0;
                            ready_reg    <= 1'b1;
                            done_reg     <= 1'b1;
                        end else begin
                            frame_reg   <= frame_next;
                            tx_reg      <= frame_next[0];
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign tx       = tx_reg;
    assign shifting = shifting_reg;
    assign ready    = ready_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: two instances (1 and 2 stop bits), each
// fed by a baud model that pulses shift every 4 clocks while shifting is high.
module tb_uart_tx_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       eight;
    logic       parity_en;
    logic       ohel;
    logic       load1, load2;
    logic       force_shift;
    logic       shift1, shift2;
    logic       shifting1, shifting2;
    logic       tx1, tx2;
    logic       ready1, ready2;
    logic       done1, done2;
    logic [1:0] cnt1, cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_framer #(.STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .load(load1), .data(data), .eight(eight),
        .parity_en(parity_en), .ohel(ohel), .shift(shift1),
        .shifting(shifting1), .tx(tx1), .ready(ready1), .done(done1)
    );

    uart_tx_framer #(.STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .load(load2), .data(data), .eight(eight),
        .parity_en(parity_en), .ohel(ohel), .shift(shift2),
        .shifting(shifting2), .tx(tx2), .ready(ready2), .done(done2)
    );

    // Baud counter models: free-run only while the framer reports shifting.
    always_ff @(posedge clk) begin
        cnt1 <= shifting1 ? cnt1 + 2'd1 : 2'd0;
        cnt2 <= shifting2 ? cnt2 + 2'd1 : 2'd0;
    end
    assign shift1 = (shifting1 && cnt1 == 2'd3) || force_shift;
    assign shift2 = (shifting2 && cnt2 == 2'd3) || force_shift;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic do_load(input bit sel, input logic [7:0] d, input logic e,
                           input logic p, input logic o, input string tag);
        data = d; eight = e; parity_en = p; ohel = o;
        if (sel) load2 = 1'b1; else load1 = 1'b1;
        @(negedge clk);
        load1 = 1'b0; load2 = 1'b0;
        chk({tag, " start_tx"},       sel ? tx2 : tx1, 1'b0);
        chk({tag, " start_shifting"}, sel ? shifting2 : shifting1, 1'b1);
        chk({tag, " start_ready"},    sel ? ready2 : ready1, 1'b0);
    endtask

    // Checks each bit in the cycle its terminating shift pulse is high,
    // then the done cycle that follows the final shift.
    task automatic expect_frame(input bit sel, input logic [11:0] exp, input int n,
                                input string tag);
        for (int i = 0; i < n; i++) begin
            int k;
            k = 0;
            while (!(sel ? shift2 : shift1) && k < 16) begin
                @(negedge clk);
                k++;
            end
            chk($sformatf("%s shift%0d_seen", tag, i), sel ? shift2 : shift1, 1'b1);
            chk($sformatf("%s bit%0d", tag, i), sel ? tx2 : tx1, exp[i]);
            chk($sformatf("%s nodone%0d", tag, i), sel ? done2 : done1, 1'b0);
            @(negedge clk);
        end
        chk({tag, " done"},     sel ? done2 : done1, 1'b1);
        chk({tag, " ready"},    sel ? ready2 : ready1, 1'b1);
        chk({tag, " shifting"}, sel ? shifting2 : shifting1, 1'b0);
        chk({tag, " idle_tx"},  sel ? tx2 : tx1, 1'b1);
        $display("frame %s: dut%0d sent %0d bit times", tag, sel ? 2 : 1, n);
    endtask

    initial begin
        rst = 1'b1; data = 8'h00; eight = 1'b1; parity_en = 1'b0; ohel = 1'b0;
        load1 = 1'b0; load2 = 1'b0; force_shift = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst tx1", tx1, 1'b1);
        chk("rst ready1", ready1, 1'b1);
        chk("rst shifting1", shifting1, 1'b0);
        chk("rst done1", done1, 1'b0);
        chk("rst tx2", tx2, 1'b1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: 0x55, 8 data bits, no parity
        do_load(1'b0, 8'h55, 1'b1, 1'b0, 1'b0, "t1_55");
        expect_frame(1'b0, 12'b1110_1010_1010, 10, "t1_55");
        repeat (2) @(negedge clk);

        // 2: 0x03 with even then odd parity
        do_load(1'b0, 8'h03, 1'b1, 1'b1, 1'b0, "t2_even");
        expect_frame(1'b0, 12'b1100_0000_0110, 11, "t2_even");
        @(negedge clk);
        do_load(1'b0, 8'h03, 1'b1, 1'b1, 1'b1, "t2_odd");
        expect_frame(1'b0, 12'b1110_0000_0110, 11, "t2_odd");
        @(negedge clk);

        // 3: 7-bit 0xFF, even parity
        do_load(1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, "t3_7bit");
        expect_frame(1'b0, 12'b1111_1111_1110, 10, "t3_7bit");
        @(negedge clk);

        // 4: mid-frame load ignored, load in done cycle starts immediately
        do_load(1'b0, 8'h55, 1'b1, 1'b0, 1'b0, "t4_55");
        data = 8'hA5; load1 = 1'b1;
        @(negedge clk);
        load1 = 1'b0;
        chk("t4 midload_ready", ready1, 1'b0);
        expect_frame(1'b0, 12'b1110_1010_1010, 10, "t4_55");
        do_load(1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, "t4_3C");
        expect_frame(1'b0, 12'b1110_0111_1000, 10, "t4_3C");
        @(negedge clk);

        // 5: reset after the third shift aborts the frame immediately
        do_load(1'b0, 8'hF0, 1'b1, 1'b0, 1'b0, "t5_abort");
        for (int s = 0; s < 3; s++) begin
            int k;
            k = 0;
            while (!shift1 && k < 16) begin
                @(negedge clk);
                k++;
            end
            chk($sformatf("t5 shift%0d_seen", s), shift1, 1'b1);
            @(negedge clk);
        end
        chk("t5 pre_rst_tx", tx1, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("t5 rst_tx", tx1, 1'b1);
        chk("t5 rst_shifting", shifting1, 1'b0);
        chk("t5 rst_ready", ready1, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_load(1'b0, 8'h81, 1'b1, 1'b0, 1'b0, "t5_81");
        expect_frame(1'b0, 12'b1111_0000_0010, 10, "t5_81");
        @(negedge clk);

        // 6: stray shift pulses while idle, then a 2-stop-bit frame
        force_shift = 1'b1;
        repeat (2) @(negedge clk);
        force_shift = 1'b0;
        chk("t6 idle_ready2", ready2, 1'b1);
        chk("t6 idle_shifting2", shifting2, 1'b0);
        chk("t6 idle_tx2", tx2, 1'b1);
        chk("t6 idle_done2", done2, 1'b0);
        chk("t6 idle_ready1", ready1, 1'b1);
        do_load(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, "t6_00");
        expect_frame(1'b1, 12'b1110_0000_0000, 11, "t6_00");
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
